// File: rtl/axi4_sram_slave_if.sv
// AXI4 manager/subordinate bundle for axi4_sram_slave: AR/R/AW/W/B channels,
// fixed 4-byte INCR beats, so size and burst type are not carried.
interface axi4_sram_slave_if #(
  parameter int ID_WIDTH = 4
);
  logic [31:0]         araddr;
  logic [ID_WIDTH-1:0] arid;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;

  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic [ID_WIDTH-1:0] rid;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [31:0]         awaddr;
  logic [ID_WIDTH-1:0] awid;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic [ID_WIDTH-1:0] bid;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arid, arlen, arvalid, input arready,
    input  rdata, rresp, rid, rlast, rvalid, output rready,
    output awaddr, awid, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bid, bvalid, output bready
  );

  modport slave (
    input  araddr, arid, arlen, arvalid, output arready,
    output rdata, rresp, rid, rlast, rvalid, input rready,
    input  awaddr, awid, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bid, bvalid, input bready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// Single-outstanding AXI4 subordinate in front of a word-addressed SRAM array.
// Define AXI_SLV_BACKPRESSURE_EN to add LFSR-driven ready/valid throttling.
module axi4_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          ID_WIDTH  = 4
) (
  input logic              clk,
  input logic              reset,
  axi4_sram_slave_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WDATA, WRESP} state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic                decerr_q, decerr_d;
  logic                slverr_q, slverr_d;
  logic                wdone_q, wdone_d;

  logic [31:0] mem_q [DEPTH];

  logic             bp_ready, bp_valid;
  logic             ar_ready_s, aw_ready_s, w_ready_s;
  logic             w_hs, mem_we, last_beat;
  logic [32:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign bp_ready = lfsr_q[0];
  assign bp_valid = lfsr_q[1];
`else
  assign bp_ready = 1'b1;
  assign bp_valid = 1'b1;
`endif

  // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
  assign offset    = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_range  = offset < 33'(4 * DEPTH);
  assign idx       = offset[IDX_W+1:2];
  assign last_beat = (beat_q == len_q);

  assign ar_ready_s = (state_q == IDLE) && !reset && bp_ready;
  assign aw_ready_s = (state_q == IDLE) && !reset && !bus.arvalid && bp_ready;
  assign w_ready_s  = (state_q == WDATA) && !wdone_q && !reset && bp_ready;
  assign w_hs       = bus.wvalid && w_ready_s;
  assign mem_we     = w_hs && in_range;

  assign bus.arready = ar_ready_s;
  assign bus.awready = aw_ready_s;
  assign bus.wready  = w_ready_s;
  assign bus.rvalid  = (state_q == RDATA);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = id_q;
  assign bus.bvalid  = (state_q == WRESP);
  assign bus.bid     = id_q;
  assign bus.bresp   = decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);

  // NOTE: every signal driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    id_d     = id_q;
    len_d    = len_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    decerr_d = decerr_q;
    slverr_d = slverr_q;
    wdone_d  = wdone_q;
    unique case (state_q)
      IDLE: begin
        if (bus.arvalid && ar_ready_s) begin
          addr_d  = {bus.araddr[31:2], 2'b00};
          id_d    = bus.arid;
          len_d   = bus.arlen;
          beat_d  = '0;
          state_d = RADDR;
        end else if (bus.awvalid && aw_ready_s) begin
          addr_d   = {bus.awaddr[31:2], 2'b00};
          id_d     = bus.awid;
          len_d    = bus.awlen;
          beat_d   = '0;
          decerr_d = 1'b0;
          slverr_d = 1'b0;
          wdone_d  = 1'b0;
          state_d  = WDATA;
        end
      end
      RADDR: begin
        rdata_d = in_range ? mem_q[idx] : '0;
        rresp_d = in_range ? 2'b00 : 2'b11;
        rlast_d = last_beat;
        if (bp_valid) state_d = RDATA;
      end
      RDATA: begin
        if (bus.rready) begin
          addr_d  = addr_q + 32'd4;
          beat_d  = beat_q + 8'd1;
          state_d = rlast_q ? IDLE : RADDR;
        end
      end
      WDATA: begin
        if (w_hs) begin
          if (!in_range) decerr_d = 1'b1;
          if (bus.wlast != last_beat) slverr_d = 1'b1;
          addr_d = addr_q + 32'd4;
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            if (bp_valid) state_d = WRESP;
            else          wdone_d = 1'b1;
          end
        end else if (wdone_q && bp_valid) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (bus.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers take non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
      decerr_q <= 1'b0;
      slverr_q <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      decerr_q <= decerr_d;
      slverr_q <= slverr_d;
      wdone_q  <= wdone_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Randomised bench for axi4_sram_slave: a transaction-level memory model plus
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_axi4_sram_slave;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          DEPTH    = 4096;
  localparam int          IDW      = 4;
  localparam logic [31:0] END_ADDR = BASE + 32'(4 * DEPTH);
  localparam int          TMO      = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi4_sram_slave_if #(.ID_WIDTH(IDW)) bus ();

  axi4_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    n_cmp++;
    n_err++;
    $display("FAIL timeout_%s: handshake not seen, required within %0d cycles", what, TMO);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic [31:0]    m_mem [DEPTH];
  rbeat_t         r_q[$];
  logic [IDW-1:0] r_id_m, b_id_m;
  bit             busy, r_act, w_act, b_act, m_dec, m_slv;
  int             r_cd, w_cd, b_cd, w_len, w_beat;
  logic [31:0]    w_addr;

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < END_ADDR);
  endfunction

  always @(negedge clk) begin : compare
    logic [31:0] a;
    bit exp_rv, exp_bv, last;
    if (r_cd > 0) r_cd--;
    if (w_cd > 0) w_cd--;
    if (b_cd > 0) b_cd--;
    exp_rv = r_act && (r_cd == 0);
    exp_bv = b_act && (b_cd == 0);
    check("arready", 32'(bus.arready), 32'(!reset && !busy));
    check("awready", 32'(bus.awready), 32'(!reset && !busy && !bus.arvalid));
    check("wready",  32'(bus.wready),  32'(!reset && w_act && w_cd == 0));
    check("rvalid",  32'(bus.rvalid),  32'(exp_rv));
    check("bvalid",  32'(bus.bvalid),  32'(exp_bv));
    if (exp_rv && bus.rvalid && r_q.size() > 0) begin
      check("rdata", bus.rdata, r_q[0].data);
      check("rresp", 32'(bus.rresp), 32'(r_q[0].resp));
      check("rlast", 32'(bus.rlast), 32'(r_q[0].last));
      check("rid",   32'(bus.rid),   32'(r_id_m));
    end
    if (exp_bv && bus.bvalid) begin
      check("bresp", 32'(bus.bresp), m_dec ? 32'd3 : (m_slv ? 32'd2 : 32'd0));
      check("bid",   32'(bus.bid),   32'(b_id_m));
    end
    if (reset) begin
      r_q.delete();
      busy = 0; r_act = 0; w_act = 0; b_act = 0;
      r_cd = 0; w_cd = 0; b_cd = 0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        for (int i = 0; i <= int'(bus.arlen); i++) begin
          rbeat_t bt;
          a = {bus.araddr[31:2], 2'b00} + 32'(4 * i);
          bt.data = in_rng(a) ? m_mem[(a - BASE) >> 2] : 32'h0;
          bt.resp = in_rng(a) ? 2'b00 : 2'b11;
          bt.last = (i == int'(bus.arlen));
          r_q.push_back(bt);
        end
        r_id_m = bus.arid;
        busy = 1; r_act = 1; r_cd = 2;
      end
      if (bus.awvalid && bus.awready) begin
        w_addr = {bus.awaddr[31:2], 2'b00};
        w_len  = int'(bus.awlen);
        w_beat = 0;
        b_id_m = bus.awid;
        m_dec = 0; m_slv = 0;
        busy = 1; w_act = 1; w_cd = 1;
      end
      if (bus.wvalid && bus.wready && w_act) begin
        a = w_addr + 32'(4 * w_beat);
        if (in_rng(a)) begin
          for (int b = 0; b < 4; b++)
            if (bus.wstrb[b]) m_mem[(a - BASE) >> 2][8*b +: 8] = bus.wdata[8*b +: 8];
        end else begin
          m_dec = 1;
        end
        if (bus.wlast != (w_beat == w_len)) m_slv = 1;
        if (w_beat == w_len) begin
          w_act = 0; b_act = 1; b_cd = 1;
        end
        w_beat++;
      end
      if (bus.rvalid && bus.rready && r_q.size() > 0) begin
        last = r_q[0].last;
        void'(r_q.pop_front());
        if (last) begin r_act = 0; busy = 0; end
        else r_cd = 2;
      end
      if (bus.bvalid && bus.bready && b_act) begin
        b_act = 0; busy = 0;
      end
    end
  end

  // ---------------- bus drivers ----------------
  logic [31:0]    wd [256];
  logic [3:0]     ws [256];
  int             wl_bad = -1;
  logic [1:0]     wr_bresp;
  logic [IDW-1:0] wr_bid;
  logic [31:0]    rd_data [256];
  logic [1:0]     rd_resp [256];
  logic           rd_last [256];
  logic [IDW-1:0] rd_id;
  int             ar_cyc, ar_lat;
  time            aw_time, r_last_time;
  int             rstall_max = 0, wgap_max = 0, bstall_max = 0;

  // Tasks start and end at posedge+1 so drives never race the negedge compare.
  task automatic axi_write(input logic [31:0] addr, input logic [IDW-1:0] id, input int len);
    int t, n;
    bus.awaddr = addr; bus.awid = id; bus.awlen = 8'(len); bus.awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.awready && t < TMO) begin @(negedge clk); t++; end
    if (!bus.awready) begin bus.awvalid = 1'b0; timeout("aw"); return; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    aw_time = $time;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, wgap_max)) begin @(posedge clk); #1; end
      bus.wdata = wd[i]; bus.wstrb = ws[i];
      bus.wlast = (i == len) ^ (i == wl_bad);
      bus.wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.wready && t < TMO) begin @(negedge clk); t++; end
      if (!bus.wready) begin bus.wvalid = 1'b0; timeout("w"); return; end
      @(posedge clk); #1;
      bus.wvalid = 1'b0;
    end
    n = $urandom_range(0, bstall_max);
    bus.bready = (n == 0);
    t = 0;
    @(negedge clk);
    while (!bus.bvalid && t < TMO) begin @(negedge clk); t++; end
    if (!bus.bvalid) begin bus.bready = 1'b0; timeout("b"); return; end
    if (n > 0) begin
      repeat (n - 1) @(negedge clk);
      @(posedge clk); #1;
      bus.bready = 1'b1;
      @(negedge clk);
    end
    wr_bresp = bus.bresp;
    wr_bid   = bus.bid;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [IDW-1:0] id, input int len,
                          input int stall_beat, input int stall_cyc);
    int t, n;
    bus.araddr = addr; bus.arid = id; bus.arlen = 8'(len); bus.arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.arready && t < TMO) begin @(negedge clk); t++; end
    if (!bus.arready) begin bus.arvalid = 1'b0; timeout("ar"); return; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    ar_cyc = cyc;
    for (int i = 0; i <= len; i++) begin
      n = (i == stall_beat) ? stall_cyc : int'($urandom_range(0, rstall_max));
      bus.rready = (n == 0);
      t = 0;
      @(negedge clk);
      while (!bus.rvalid && t < TMO) begin @(negedge clk); t++; end
      if (!bus.rvalid) begin bus.rready = 1'b0; timeout("r"); return; end
      if (i == 0) ar_lat = cyc - ar_cyc;
      if (n > 0) begin
        repeat (n - 1) @(negedge clk);
        @(posedge clk); #1;
        bus.rready = 1'b1;
        @(negedge clk);
      end
      rd_data[i] = bus.rdata;
      rd_resp[i] = bus.rresp;
      rd_last[i] = bus.rlast;
      rd_id      = bus.rid;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      r_last_time = $time;
    end
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] a;
    int len, sel, cnt;
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rlast",   32'(bus.rlast),   32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_rresp",   32'(bus.rresp),   32'd0);
    check("rst_rid",     32'(bus.rid),     32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'd0);
    check("rst_bid",     32'(bus.bid),     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // write then read back
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(BASE + 32'h10, 4'd1, 0);
    check("wr1_bresp", 32'(wr_bresp), 32'd0);
    check("wr1_bid",   32'(wr_bid),   32'd1);
    axi_read(BASE + 32'h10, 4'd1, 0, -1, 0);
    check("rd1_data",    rd_data[0],         32'hDEADBEEF);
    check("rd1_resp",    32'(rd_resp[0]),    32'd0);
    check("rd1_last",    32'(rd_last[0]),    32'd1);
    check("rd1_id",      32'(rd_id),         32'd1);
    check("rd1_latency", 32'(ar_lat),        32'd1);

    // byte strobe merge
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_write(BASE + 32'h20, 4'd2, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0010;
    axi_write(BASE + 32'h20, 4'd2, 0);
    axi_read(BASE + 32'h20, 4'd2, 0, -1, 0);
    check("strb_data", rd_data[0], 32'h1122CC44);

    // burst read with a 3-cycle stall on beat 1
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    axi_write(BASE, 4'd3, 3);
    axi_read(BASE, 4'd3, 3, 1, 3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_data%0d", i), rd_data[i], 32'(i));
      check($sformatf("burst_last%0d", i), 32'(rd_last[i]), 32'(i == 3));
    end

    // decode error on both channels
    axi_read(END_ADDR, 4'd4, 0, -1, 0);
    check("dec_rdata", rd_data[0], 32'd0);
    check("dec_rresp", 32'(rd_resp[0]), 32'd3);
    wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
    axi_write(END_ADDR - 32'd4, 4'd4, 0);
    wd[0] = 32'hFFFFFFFF;
    axi_write(END_ADDR, 4'd4, 0);
    check("dec_bresp", 32'(wr_bresp), 32'd3);
    axi_read(END_ADDR - 32'd4, 4'd4, 0, -1, 0);
    check("dec_lastword", rd_data[0], 32'h5A5A5A5A);

    // read/write collision: read wins, write waits for rlast
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    fork
      axi_read(BASE + 32'h10, 4'd2, 0, 0, 2);
      axi_write(BASE + 32'h30, 4'd3, 0);
      begin
        @(negedge clk);
        check("coll_arready", 32'(bus.arready), 32'd1);
        check("coll_awready", 32'(bus.awready), 32'd0);
      end
    join
    check("coll_order", 32'(aw_time > r_last_time), 32'd1);
    check("coll_rdata", rd_data[0], 32'hDEADBEEF);

    // early wlast on a 2-beat write
    wd[0] = 32'h1; wd[1] = 32'h2; ws[0] = 4'hF; ws[1] = 4'hF; wl_bad = 0;
    axi_write(BASE + 32'h40, 4'd6, 1);
    wl_bad = -1;
    check("slverr_bresp", 32'(wr_bresp), 32'd2);

    // reset in the middle of a read burst
    bus.araddr = BASE; bus.arid = 4'd5; bus.arlen = 8'd3; bus.arvalid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!bus.arready && cnt < TMO) begin @(negedge clk); cnt++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!bus.rvalid && cnt < TMO) begin @(negedge clk); cnt++; end
    if (!bus.rvalid) timeout("rst_r");
    @(posedge clk); #1;
    bus.rready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_arready", 32'(bus.arready), 32'd1);
    cnt = 0;
    bus.rready = 1'b1;
    repeat (10) begin @(negedge clk); if (bus.rvalid) cnt++; end
    check("mid_rst_nobeats", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    bus.rready = 1'b0;

    // prefill the random window so every model word is defined
    for (int i = 0; i < 32; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(BASE, 4'd7, 31);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(END_ADDR - 32'd16, 4'd7, 3);

    rstall_max = 2; wgap_max = 2; bstall_max = 2;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        a = BASE + 32'(4 * $urandom_range(0, 24)); len = $urandom_range(0, 7);
      end else if (sel < 9) begin
        a = END_ADDR - 32'd16 + 32'(4 * $urandom_range(0, 5)); len = $urandom_range(0, 5);
      end else begin
        a = BASE - 32'd16; len = $urandom_range(0, 7);
      end
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        axi_read(a, 4'($urandom_range(0, 15)), len, -1, 0);
      end else begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        wl_bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1;
        axi_write(a, 4'($urandom_range(0, 15)), len);
        wl_bad = -1;
      end
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
